fir_sample_source: RTL and testbench

Streaming sample transmitter that drives the FIR system's sample input, i.e. its data_in/data_in_valid pair. Host writes samples into an internal FIFO, then pulses start. The block emits each sample as a single-cycle tx_valid pulse, with a programmable number of idle cycles between pulses. There is no backpressure: the FIR side must accept every pulse. The block replaces ad-hoc stimulus with synthesizable, repeatable traffic generation.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/fir_sample_source.sv | 197 +++++++++++++++++++
 tb/tb_fir_sample_source.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample source and its bench.
// Holds the default sample width, the transmitter FSM encoding
// and the default inter-sample gap used by stimulus.
package fir_pkg;

  // Sample width of the FIR data path.
  localparam int FIR_DATA_WIDTH = 16;

  // Default number of idle cycles between transmitted samples.
  localparam int GAP_DEFAULT = 10;

  // Transmitter control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } src_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock first-word-fall-through FIFO with synchronous flush.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; flush wins over both.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  // Status comes from the registered occupancy only, so a push while
  // full is rejected even if a pop happens in the same cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed since empty guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_source.sv
// Purpose: replays host-loaded samples to the FIR input as single-cycle valid pulses.
// Latency: first tx_valid one cycle after start is sampled; pulses spaced by gap idle cycles.
// Backpressure: none on the tx side; host writes while full are dropped and flagged.
module fir_sample_source
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  overflow,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid
);

  src_state_t            state;
  src_state_t            state_nxt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_push;
  logic                  fifo_pop;

  logic [GAP_WIDTH-1:0]  gap_lat;
  logic [GAP_WIDTH-1:0]  gap_cnt;

  logic                  aborting;
  logic                  run_start;
  logic                  launch;
  logic                  gap_load;
  logic                  gap_dec;

  // Abort only acts on an active run; it then outranks writes and start.
  assign aborting  = abort & (state != ST_IDLE);
  assign fifo_push = wr_en & ~fifo_full & ~aborting;

  assign wr_full = fifo_full;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (aborting),
    .wdata (wr_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (fifo_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes. "launch" marks the edge that enters
  // SEND: the FIFO head is popped into the tx register on that edge so
  // the pulse is visible during the SEND cycle itself.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    launch    = 1'b0;
    run_start = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (!fifo_empty) begin
            state_nxt = ST_SEND;
            fifo_pop  = 1'b1;
            launch    = 1'b1;
            run_start = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (gap_lat != '0) begin
          state_nxt = ST_GAP;
          gap_load  = 1'b1;
        end else if (!fifo_empty) begin
          state_nxt = ST_SEND;
          fifo_pop  = 1'b1;
          launch    = 1'b1;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          if (!fifo_empty) begin
            state_nxt = ST_SEND;
            fifo_pop  = 1'b1;
            launch    = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (aborting) begin
      state_nxt = ST_IDLE;
      fifo_pop  = 1'b0;
      launch    = 1'b0;
      run_start = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
    end
  end

  // Gap latch and down-counter; loading gap-1 on leaving SEND gives
  // exactly gap cycles in GAP (the zero cycle is the last one).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_lat <= '0;
      gap_cnt <= '0;
    end else begin
      if (run_start) begin
        gap_lat <= gap_cycles;
      end
      if (gap_load) begin
        gap_cnt <= gap_lat - 1'b1;
      end else if (gap_dec) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // Transmit register: one valid cycle per popped sample, data held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= launch;
      if (launch) begin
        tx_data <= fifo_rdata;
      end
    end
  end

  // Sample counter: restarts at one on an accepted start (that edge also
  // sends the first sample), otherwise counts every launch and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_count <= '0;
    end else if (run_start) begin
      sample_count <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (launch) begin
      sample_count <= sample_count + 1'b1;
    end
  end

  // Sticky overflow flag; a new run starts with a clean flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (run_start) begin
      overflow <= 1'b0;
    end else if (wr_en && fifo_full && !aborting) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_source.sv
// Directed bench for fir_sample_source: loads samples, starts runs and
// checks pulse data, pulse timing, done/busy timing, overflow, abort and
// asynchronous reset against hand-computed values.
module tb_fir_sample_source;
  import fir_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic        overflow;
  logic [7:0]  gap_cycles;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] sample_count;
  logic [15:0] tx_data;
  logic        tx_valid;

  int tests_run;
  int tests_failed;

  int          pulse_cyc[$];
  logic [15:0] pulse_dat[$];
  int          done_cyc[$];
  int          busy_cnt;

  fir_sample_source dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .overflow     (overflow),
    .gap_cycles   (gap_cycles),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic write_sample(input logic [15:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] gap);
    gap_cycles = gap;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
  endtask

  // Cycle 0 is the cycle right after the start edge; samples at falling edges.
  task automatic capture(input int ncyc);
    pulse_cyc.delete();
    pulse_dat.delete();
    done_cyc.delete();
    busy_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (tx_valid) begin
        pulse_cyc.push_back(c);
        pulse_dat.push_back(tx_data);
      end
      if (done) done_cyc.push_back(c);
      if (busy) busy_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_full"},  32'(wr_full),      32'd0);
    check({tag, "_overflow"}, 32'(overflow),     32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_done"},     32'(done),         32'd0);
    check({tag, "_count"},    32'(sample_count), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),      32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid),     32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b0;
    wr_data    = '0;
    wr_en      = 1'b0;
    gap_cycles = '0;
    start      = 1'b0;
    abort      = 1'b0;
    #3;
    check_outputs_zero("reset");
    #14;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: five samples, default gap of 10 -> pulses 11 cycles apart.
    for (int i = 1; i <= 5; i++) write_sample(16'(i));
    pulse_start(8'(GAP_DEFAULT));
    capture(70);
    check("t1_npulse", 32'(pulse_cyc.size()), 32'd5);
    for (int k = 0; k < 5 && k < pulse_cyc.size(); k++) begin
      check($sformatf("t1_data%0d", k), 32'(pulse_dat[k]), 32'(k + 1));
      check($sformatf("t1_cyc%0d", k),  32'(pulse_cyc[k]), 32'(11 * k));
    end
    check("t1_ndone", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("t1_done_cyc", 32'(done_cyc[0]), 32'd55);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd56);
    check("t1_count", 32'(sample_count), 32'd5);

    // 2: same data, no gap -> back-to-back pulses, done next cycle.
    for (int i = 1; i <= 5; i++) write_sample(16'(i));
    pulse_start(8'd0);
    capture(12);
    check("t2_npulse", 32'(pulse_cyc.size()), 32'd5);
    for (int k = 0; k < 5 && k < pulse_cyc.size(); k++) begin
      check($sformatf("t2_data%0d", k), 32'(pulse_dat[k]), 32'(k + 1));
      check($sformatf("t2_cyc%0d", k),  32'(pulse_cyc[k]), 32'(k));
    end
    check("t2_ndone", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("t2_done_cyc", 32'(done_cyc[0]), 32'd5);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd6);

    // 3: nine writes into an eight-deep FIFO.
    for (int i = 0; i < 8; i++) write_sample(16'h10 + 16'(i));
    check("t3_full_after8", 32'(wr_full), 32'd1);
    check("t3_ovf_after8", 32'(overflow), 32'd0);
    write_sample(16'h18);
    check("t3_ovf_after9", 32'(overflow), 32'd1);
    pulse_start(8'd0);
    check("t3_ovf_cleared", 32'(overflow), 32'd0);
    check("t3_full_after_pop", 32'(wr_full), 32'd0);
    capture(14);
    check("t3_npulse", 32'(pulse_cyc.size()), 32'd8);
    for (int k = 0; k < 8 && k < pulse_cyc.size(); k++)
      check($sformatf("t3_data%0d", k), 32'(pulse_dat[k]), 32'h10 + 32'(k));
    check("t3_count", 32'(sample_count), 32'd8);

    // 4: start with an empty FIFO.
    pulse_start(8'd3);
    capture(6);
    check("t4_npulse", 32'(pulse_cyc.size()), 32'd0);
    check("t4_ndone", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("t4_done_cyc", 32'(done_cyc[0]), 32'd0);
    check("t4_busy_cycles", 32'(busy_cnt), 32'd1);
    check("t4_count_kept", 32'(sample_count), 32'd8);

    // 5: abort after the second pulse.
    for (int i = 1; i <= 5; i++) write_sample(16'(i));
    pulse_start(8'(GAP_DEFAULT));
    capture(13);
    check("t5_npulse_pre", 32'(pulse_cyc.size()), 32'd2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_valid_after", 32'(tx_valid), 32'd0);
    capture(60);
    check("t5_npulse_post", 32'(pulse_cyc.size()), 32'd0);
    check("t5_ndone_post", 32'(done_cyc.size()), 32'd0);
    check("t5_count", 32'(sample_count), 32'd2);
    // A flushed FIFO makes the next start finish at once with no pulse.
    pulse_start(8'd0);
    capture(4);
    check("t5_flush_npulse", 32'(pulse_cyc.size()), 32'd0);
    check("t5_flush_ndone", 32'(done_cyc.size()), 32'd1);

    // 6: asynchronous reset in the middle of a gap.
    for (int i = 1; i <= 3; i++) write_sample(16'(i));
    pulse_start(8'(GAP_DEFAULT));
    capture(3);
    check("t6_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    pulse_start(8'd0);
    capture(4);
    check("t6_empty_npulse", 32'(pulse_cyc.size()), 32'd0);
    check("t6_empty_ndone", 32'(done_cyc.size()), 32'd1);
    write_sample(16'd7);
    write_sample(16'd8);
    pulse_start(8'd2);
    capture(10);
    check("t6_npulse", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) begin
      check("t6_data0", 32'(pulse_dat[0]), 32'd7);
      check("t6_data1", 32'(pulse_dat[1]), 32'd8);
      check("t6_cyc1",  32'(pulse_cyc[1]), 32'd3);
    end
    if (done_cyc.size() > 0) check("t6_done_cyc", 32'(done_cyc[0]), 32'd6);
    else check("t6_ndone", 32'(done_cyc.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
